// File: rtl/pcie_tx_pkg.sv
// Shared encodings for the PCIe TX lane framer: link generation codes,
// 128b/130b sync headers, block geometry and the block/gap FSM states.
package pcie_tx_pkg;

  typedef enum logic [2:0] {
    GEN1 = 3'd1,
    GEN2 = 3'd2,
    GEN3 = 3'd3
  } pcie_gen_e;

  localparam logic [1:0] SYNC_DATA   = 2'b10;
  localparam logic [1:0] SYNC_OS     = 2'b01;
  localparam int         BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLOCK = 2'd1,
    ST_GAP   = 2'd2
  } framer_state_e;

  // Any generation code of 3 or above uses 128b/130b block framing.
  function automatic logic isBlockGen(input logic [2:0] gen);
    return gen >= 3'(GEN3);
  endfunction

  // A zero or out-of-range negotiated width falls back to the full lane count.
  function automatic logic [4:0] sanitizeLanes(input logic [4:0] req, input int lanes);
    if (req == 5'd0 || int'(req) > lanes) return 5'(lanes);
    return req;
  endfunction

endpackage

// File: rtl/pcie_tx_lane_framer_if.sv
// Bus bundle between the TX data mux (master) and the lane framer (slave),
// including the PIPE-side per-lane outputs.
// Optional feature macro: TX_FRAMER_LANE_REVERSAL_EN adds lane_reverse.
interface pcie_tx_lane_framer_if #(
  parameter int LANES      = 16,
  parameter int PIPE_BYTES = 4
);
  logic [2:0]                  gen;
  logic [4:0]                  active_lanes;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*PIPE_BYTES*8-1:0] in_data;
  logic [LANES*PIPE_BYTES-1:0] in_k;
  logic                        in_os;
`ifdef TX_FRAMER_LANE_REVERSAL_EN
  logic                        lane_reverse;
`endif
  logic [LANES*PIPE_BYTES*8-1:0] TxData;
  logic [LANES*PIPE_BYTES-1:0] TxDataK;
  logic [LANES-1:0]            TxDataValid;
  logic [LANES-1:0]            TxStartBlock;
  logic [2*LANES-1:0]          TxSyncHeader;
  logic                        err_underrun;

`ifdef TX_FRAMER_LANE_REVERSAL_EN
  modport master (
    output gen, active_lanes, in_valid, in_data, in_k, in_os, lane_reverse,
    input  in_ready, TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, err_underrun
  );
  modport slave (
    input  gen, active_lanes, in_valid, in_data, in_k, in_os, lane_reverse,
    output in_ready, TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, err_underrun
  );
`else
  modport master (
    output gen, active_lanes, in_valid, in_data, in_k, in_os,
    input  in_ready, TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, err_underrun
  );
  modport slave (
    input  gen, active_lanes, in_valid, in_data, in_k, in_os,
    output in_ready, TxData, TxDataK, TxDataValid, TxStartBlock, TxSyncHeader, err_underrun
  );
`endif

endinterface

// File: rtl/tx_block_gap_ctrl.sv
// Block/gap controller: tracks 128b/130b word and block counts, inserts the
// one-cycle TxDataValid gap every GAP_BLOCKS completed blocks and flags
// mid-block underruns. Generation is latched at block start only.
module tx_block_gap_ctrl
  import pcie_tx_pkg::*;
#(
  parameter int PIPE_BYTES = 4,
  parameter int GAP_BLOCKS = 4 * PIPE_BYTES
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       in_valid_i,
  input  logic [2:0] gen_i,
  output logic       in_ready_o,
  output logic       xfer_o,
  output logic       idle_o,
  output logic       blockMode_o,
  output logic       start_o,
  output logic       gap_o,
  output logic       underrun_o
);

  localparam int WORDS = BLOCK_BYTES / PIPE_BYTES;
  localparam int WCW   = $clog2(WORDS + 1);
  localparam int BCW   = $clog2(GAP_BLOCKS + 1);

  framer_state_e  state_q, state_d;
  logic [WCW-1:0] wordCnt_q, wordCnt_d;
  logic [BCW-1:0] blockCnt_q, blockCnt_d;
  logic           blockMode_q, blockMode_d;
  logic           readyEn_q;
  logic           effBlockMode;
  logic           inReady;
  logic           xfer;

  assign effBlockMode = (state_q == ST_IDLE) ? isBlockGen(gen_i) : blockMode_q;
  assign inReady      = readyEn_q && (state_q != ST_GAP);
  assign xfer         = in_valid_i && inReady;

  // State and counter registers; in_ready is held off until the first clock after reset.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wordCnt_q   <= '0;
      blockCnt_q  <= '0;
      blockMode_q <= 1'b0;
      readyEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCnt_q   <= wordCnt_d;
      blockCnt_q  <= blockCnt_d;
      blockMode_q <= blockMode_d;
      readyEn_q   <= 1'b1;
    end
  end

  // Next state: open a block from IDLE, count words, close block and maybe enter GAP.
  always_comb begin
    state_d     = state_q;
    wordCnt_d   = wordCnt_q;
    blockCnt_d  = blockCnt_q;
    blockMode_d = blockMode_q;
    case (state_q)
      ST_IDLE: begin
        blockMode_d = effBlockMode;
        if (xfer && effBlockMode) begin
          state_d   = ST_BLOCK;
          wordCnt_d = WCW'(1);
        end
      end
      ST_BLOCK: begin
        if (in_valid_i) begin
          if (wordCnt_q == WCW'(WORDS - 1)) begin
            wordCnt_d  = '0;
            blockCnt_d = blockCnt_q + BCW'(1);
            state_d    = (blockCnt_q == BCW'(GAP_BLOCKS - 1)) ? ST_GAP : ST_IDLE;
          end else begin
            wordCnt_d = wordCnt_q + WCW'(1);
          end
        end
      end
      ST_GAP: begin
        blockCnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and the live handshake.
  always_comb begin
    in_ready_o  = inReady;
    xfer_o      = xfer;
    idle_o      = (state_q == ST_IDLE);
    blockMode_o = effBlockMode;
    start_o     = xfer && effBlockMode && (state_q == ST_IDLE);
    gap_o       = (state_q == ST_GAP);
    underrun_o  = (state_q == ST_BLOCK) && !in_valid_i;
  end

endmodule

// File: rtl/pcie_tx_lane_framer.sv
// Per-lane TX framing stage: splits one wide word into LANES PIPE words with
// one pclk of latency, drives TxStartBlock/TxSyncHeader at Gen3+ and masks
// lanes beyond the negotiated width.
// Optional feature macro: TX_FRAMER_LANE_REVERSAL_EN (logical lane i drives
// physical lane active_lanes-1-i when lane_reverse is set).
module pcie_tx_lane_framer
  import pcie_tx_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int PIPE_BYTES = 4,
  parameter int GAP_BLOCKS = 4 * PIPE_BYTES
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  pcie_tx_lane_framer_if.slave   bus
);

  localparam int W = PIPE_BYTES * 8;

  logic inReady, xfer, idle, blockMode, start, gap, underrun;

  tx_block_gap_ctrl #(
    .PIPE_BYTES (PIPE_BYTES),
    .GAP_BLOCKS (GAP_BLOCKS)
  ) u_ctrl (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .in_valid_i  (bus.in_valid),
    .gen_i       (bus.gen),
    .in_ready_o  (inReady),
    .xfer_o      (xfer),
    .idle_o      (idle),
    .blockMode_o (blockMode),
    .start_o     (start),
    .gap_o       (gap),
    .underrun_o  (underrun)
  );

  assign bus.in_ready = inReady;

  logic [4:0] reqLanes, effLanes, cfgLanes_q;
  logic       errUnderrun_q;

  assign reqLanes = sanitizeLanes(bus.active_lanes, LANES);
  assign effLanes = idle ? reqLanes : cfgLanes_q;

`ifdef TX_FRAMER_LANE_REVERSAL_EN
  logic cfgReverse_q, effReverse;
  assign effReverse = idle ? bus.lane_reverse : cfgReverse_q;

  // Lane reversal setting is frozen for the duration of a block.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n)  cfgReverse_q <= 1'b0;
    else if (idle) cfgReverse_q <= bus.lane_reverse;
  end
`endif

  // Link width is frozen for the duration of a block; underrun pulse is registered.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cfgLanes_q    <= 5'(LANES);
      errUnderrun_q <= 1'b0;
    end else begin
      if (idle) cfgLanes_q <= reqLanes;
      errUnderrun_q <= underrun;
    end
  end

  assign bus.err_underrun = errUnderrun_q;

  logic [LANES-1:0][W-1:0]          txData;
  logic [LANES-1:0][PIPE_BYTES-1:0] txK;
  logic [LANES-1:0]                 txValid;
  logic [LANES-1:0]                 txStart;
  logic [LANES-1:0][1:0]            txHdr;

  assign bus.TxData       = txData;
  assign bus.TxDataK      = txK;
  assign bus.TxDataValid  = txValid;
  assign bus.TxStartBlock = txStart;
  assign bus.TxSyncHeader = txHdr;

  for (genvar p = 0; p < LANES; p++) begin : g_lane
    logic                  laneActive;
    int                    srcLane;
    logic [W-1:0]          data_q, data_d;
    logic [PIPE_BYTES-1:0] k_q, k_d;
    logic                  valid_q, valid_d;
    logic                  start_q, start_d;
    logic [1:0]            hdr_q, hdr_d;

    assign laneActive = (p < int'(effLanes));
`ifdef TX_FRAMER_LANE_REVERSAL_EN
    assign srcLane = effReverse ? (int'(effLanes) - 1 - p) : p;
`else
    assign srcLane = p;
`endif

    // Lane next values: inactive lanes idle at zero, data/K/header load only on their events.
    always_comb begin
      data_d  = data_q;
      k_d     = k_q;
      hdr_d   = hdr_q;
      valid_d = laneActive && xfer && !gap;
      start_d = laneActive && start;
      if (!laneActive) begin
        data_d = '0;
        k_d    = '0;
        hdr_d  = '0;
      end else begin
        if (xfer) begin
          data_d = bus.in_data[srcLane*W +: W];
          k_d    = blockMode ? '0 : bus.in_k[srcLane*PIPE_BYTES +: PIPE_BYTES];
        end
        if (start)                 hdr_d = bus.in_os ? SYNC_OS : SYNC_DATA;
        else if (idle && !blockMode) hdr_d = '0;
      end
    end

    // Lane output registers.
    always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
        data_q  <= '0;
        k_q     <= '0;
        valid_q <= 1'b0;
        start_q <= 1'b0;
        hdr_q   <= '0;
      end else begin
        data_q  <= data_d;
        k_q     <= k_d;
        valid_q <= valid_d;
        start_q <= start_d;
        hdr_q   <= hdr_d;
      end
    end

    assign txData[p]  = data_q;
    assign txK[p]     = k_q;
    assign txValid[p] = valid_q;
    assign txStart[p] = start_q;
    assign txHdr[p]   = hdr_q;
  end

endmodule
